// File: rtl/l2_request_arbiter.sv
// Three-requester arbiter onto one shared L2 request port; a grant locks until the L2 accepts it.
// Define L2_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority req0 > req1 > req2.
module l2_request_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_unit,
  input  logic [1:0]   req0_strand,
  input  logic [2:0]   req0_op,
  input  logic [1:0]   req0_way,
  input  logic [25:0]  req0_address,
  input  logic [511:0] req0_data,
  input  logic [63:0]  req0_mask,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_unit,
  input  logic [1:0]   req1_strand,
  input  logic [2:0]   req1_op,
  input  logic [1:0]   req1_way,
  input  logic [25:0]  req1_address,
  input  logic [511:0] req1_data,
  input  logic [63:0]  req1_mask,
  input  logic         req2_valid,
  output logic         req2_ready,
  input  logic [1:0]   req2_unit,
  input  logic [1:0]   req2_strand,
  input  logic [2:0]   req2_op,
  input  logic [1:0]   req2_way,
  input  logic [25:0]  req2_address,
  input  logic [511:0] req2_data,
  input  logic [63:0]  req2_mask,
  output logic         l2req_valid,
  output logic [1:0]   l2req_unit,
  output logic [1:0]   l2req_strand,
  output logic [2:0]   l2req_op,
  output logic [1:0]   l2req_way,
  output logic [25:0]  l2req_address,
  output logic [511:0] l2req_data,
  output logic [63:0]  l2req_mask,
  input  logic         l2req_ready
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] locked_oh, locked_oh_nxt;
  logic [2:0] valid, arb_oh, grant_oh, ready;
  logic       accept;

  assign valid = {req2_valid, req1_valid, req0_valid};

`ifdef L2_ARB_ROUND_ROBIN_EN
  logic [2:0] last_grant;

  // Scan starts at the requester after the most recently accepted one.
  always_comb begin
    arb_oh = '0;
    case (last_grant)
      3'b001: begin
        if      (valid[1]) arb_oh = 3'b010;
        else if (valid[2]) arb_oh = 3'b100;
        else if (valid[0]) arb_oh = 3'b001;
      end
      3'b010: begin
        if      (valid[2]) arb_oh = 3'b100;
        else if (valid[0]) arb_oh = 3'b001;
        else if (valid[1]) arb_oh = 3'b010;
      end
      default: begin
        if      (valid[0]) arb_oh = 3'b001;
        else if (valid[1]) arb_oh = 3'b010;
        else if (valid[2]) arb_oh = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= 3'b100;
    else if (accept) last_grant <= grant_oh;
  end
`else
  always_comb begin
    arb_oh = '0;
    if      (valid[0]) arb_oh = 3'b001;
    else if (valid[1]) arb_oh = 3'b010;
    else if (valid[2]) arb_oh = 3'b100;
  end
`endif

  assign grant_oh = (state == LOCKED) ? locked_oh : arb_oh;
  assign ready    = grant_oh & valid & {3{l2req_ready & ~reset}};
  assign accept   = |ready;

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign req2_ready = ready[2];

  always_comb begin
    state_nxt     = state;
    locked_oh_nxt = locked_oh;
    unique case (state)
      IDLE: begin
        if (|grant_oh && !l2req_ready) begin
          state_nxt     = LOCKED;
          locked_oh_nxt = grant_oh;
        end
      end
      LOCKED: begin
        if (accept) begin
          state_nxt     = IDLE;
          locked_oh_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      locked_oh <= '0;
    end else begin
      state     <= state_nxt;
      locked_oh <= locked_oh_nxt;
    end
  end

  // grant_oh is one-hot or zero, so an AND-OR mux yields all-zero outputs with no grant.
  assign l2req_valid   = |(grant_oh & valid);
  assign l2req_unit    = ({2{grant_oh[0]}}   & req0_unit)    | ({2{grant_oh[1]}}   & req1_unit)    | ({2{grant_oh[2]}}   & req2_unit);
  assign l2req_strand  = ({2{grant_oh[0]}}   & req0_strand)  | ({2{grant_oh[1]}}   & req1_strand)  | ({2{grant_oh[2]}}   & req2_strand);
  assign l2req_op      = ({3{grant_oh[0]}}   & req0_op)      | ({3{grant_oh[1]}}   & req1_op)      | ({3{grant_oh[2]}}   & req2_op);
  assign l2req_way     = ({2{grant_oh[0]}}   & req0_way)     | ({2{grant_oh[1]}}   & req1_way)     | ({2{grant_oh[2]}}   & req2_way);
  assign l2req_address = ({26{grant_oh[0]}}  & req0_address) | ({26{grant_oh[1]}}  & req1_address) | ({26{grant_oh[2]}}  & req2_address);
  assign l2req_data    = ({512{grant_oh[0]}} & req0_data)    | ({512{grant_oh[1]}} & req1_data)    | ({512{grant_oh[2]}} & req2_data);
  assign l2req_mask    = ({64{grant_oh[0]}}  & req0_mask)    | ({64{grant_oh[1]}}  & req1_mask)    | ({64{grant_oh[2]}}  & req2_mask);

  // A locked requester must hold valid until the L2 accepts it.
  assert property (@(posedge clk) disable iff (reset) (state == LOCKED) |-> |(locked_oh & valid))
    else $warning("l2_request_arbiter: locked requester dropped valid before acceptance");

endmodule
